// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundle between the instruction-fetch stage and its neighbours (decode and
// the instruction loader).
//   master : decode/loader side. Drives run enable, stall, branch/jump
//            redirects and the instruction-memory write port. Observes PC,
//            the IF/ID register and the halt flag.
//   slave  : the fetch stage itself (if_stage).
// Signal names keep their i_/o_ prefixes as seen from the fetch stage.
// -----------------------------------------------------------------------------
interface if_stage_if;
  logic        i_enable;
  logic        i_stall;
  logic        i_pc_src;
  logic [31:0] i_beq_jump_dir;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_imem_we;
  logic [31:0] i_imem_waddr;
  logic [31:0] i_imem_wdata;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus_4;
  logic        o_halt;

  modport master (
    output i_enable, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_addr,
           i_imem_we, i_imem_waddr, i_imem_wdata,
    input  o_pc, o_instruction, o_pc_plus_4, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_addr,
           i_imem_we, i_imem_waddr, i_imem_wdata,
    output o_pc, o_instruction, o_pc_plus_4, o_halt
  );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS
// pipeline.
//   - PC register and an internal loadable instruction memory (combinational
//     read, synchronous write only while the pipeline is disabled).
//   - Next PC chosen from decode's redirects: branch beats jump beats PC+4.
//   - IF/ID latches {instruction, PC+4}; held on stall, flushed to a NOP
//     bubble on a taken redirect.
//   - A HALT word committed into IF/ID freezes fetch until reset.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous, active-high reset
//   bus     : if_stage_if.slave (control inputs, imem write port,
//             o_pc / o_instruction / o_pc_plus_4 / o_halt)
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic      i_clk,
  input  logic      i_reset,
  if_stage_if.slave bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // PC increment; 32-bit unsigned wrap is intended (0xFFFF_FFFC -> 0).
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [31:0] imem [IMEM_DEPTH];

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_p0;
  logic [31:0] pc_d;
  logic [31:0] instr_p1;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_4_p1;
  logic [31:0] pc_plus_4_d;

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   fetch_word;
  logic [31:0]   seq_pc;
  logic          advance;
  logic          redirect;
  logic          halt_hit;
  logic          unused_addr_bits;

  // Word index only; upper address bits alias, so fetch wraps modulo depth.
  assign rd_idx     = pc_p0[AW+1:2];
  assign wr_idx     = bus.i_imem_waddr[AW+1:2];
  assign fetch_word = imem[rd_idx];
  assign seq_pc     = pc_inc(pc_p0);

  assign unused_addr_bits = ^{pc_p0[31:AW+2], pc_p0[1:0],
                              bus.i_imem_waddr[31:AW+2], bus.i_imem_waddr[1:0]};

  // Stall dominates redirects: decode re-presents the redirect afterwards.
  assign advance  = bus.i_enable && (state_q == ST_RUN) && !bus.i_stall;
  assign redirect = advance && (bus.i_pc_src || bus.i_jump);
  assign halt_hit = advance && !redirect && (fetch_word == HALT_WORD);

  // Loader port: writes only land while the pipeline is disabled.
  always_ff @(posedge i_clk) begin
    if (bus.i_imem_we && !bus.i_enable) begin
      imem[wr_idx] <= bus.i_imem_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_p0;
    instr_d     = instr_p1;
    pc_plus_4_d = pc_plus_4_p1;

    unique case (state_q)
      ST_RUN: begin
        if (advance) begin
          if (bus.i_pc_src) begin
            pc_d        = bus.i_beq_jump_dir;
            instr_d     = '0;
            pc_plus_4_d = '0;
          end else if (bus.i_jump) begin
            pc_d        = bus.i_jump_addr;
            instr_d     = '0;
            pc_plus_4_d = '0;
          end else begin
            instr_d     = fetch_word;
            pc_plus_4_d = seq_pc;
            // HALT enters IF/ID normally but the PC stays parked on it.
            if (halt_hit) begin
              state_d = ST_HALT;
            end else begin
              pc_d = seq_pc;
            end
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---- stage boundary: PC (p0) and IF/ID (p1) registers ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_p0        <= PC_RESET;
      instr_p1     <= '0;
      pc_plus_4_p1 <= '0;
    end else begin
      pc_p0        <= pc_d;
      instr_p1     <= instr_d;
      pc_plus_4_p1 <= pc_plus_4_d;
    end
  end

  assign bus.o_pc          = pc_p0;
  assign bus.o_instruction = instr_p1;
  assign bus.o_pc_plus_4   = pc_plus_4_p1;
  assign bus.o_halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed scenarios for fetch, stall, redirect priority, HALT and reset,
// followed by randomized traffic checked against a cycle-level reference
// model of the fetch stage. Observations are packed as
// {pc, instruction, pc_plus_4, halt} (97 bits) for each comparison.
// -----------------------------------------------------------------------------
module tb_if_stage;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_stage_if bus();

  if_stage #(
    .IMEM_DEPTH(256),
    .PC_RESET  (32'h0000_0000),
    .HALT_WORD (HALT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_p4;
  logic        m_halt;

  function automatic logic [96:0] snap();
    return {bus.o_pc, bus.o_instruction, bus.o_pc_plus_4, bus.o_halt};
  endfunction

  function automatic logic [96:0] model_snap();
    return {m_pc, m_instr, m_p4, m_halt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_p4    = 32'h0;
    m_halt  = 1'b0;
  endtask

  // One clock edge of the fetch stage, computed from the current inputs.
  task automatic model_step();
    logic [31:0] word;
    word = m_mem[m_pc[9:2]];
    if (bus.i_imem_we && !bus.i_enable) m_mem[bus.i_imem_waddr[9:2]] = bus.i_imem_wdata;
    if (bus.i_enable && !m_halt && !bus.i_stall) begin
      if (bus.i_pc_src) begin
        m_pc = bus.i_beq_jump_dir; m_instr = 32'h0; m_p4 = 32'h0;
      end else if (bus.i_jump) begin
        m_pc = bus.i_jump_addr; m_instr = 32'h0; m_p4 = 32'h0;
      end else begin
        m_instr = word;
        m_p4    = m_pc + 32'd4;
        if (word == HALT) m_halt = 1'b1;
        else              m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic clear_ctl();
    bus.i_enable       = 1'b0;
    bus.i_stall        = 1'b0;
    bus.i_pc_src       = 1'b0;
    bus.i_beq_jump_dir = 32'h0;
    bus.i_jump         = 1'b0;
    bus.i_jump_addr    = 32'h0;
    bus.i_imem_we      = 1'b0;
    bus.i_imem_waddr   = 32'h0;
    bus.i_imem_wdata   = 32'h0;
  endtask

  // Pulse reset between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    bus.i_enable     = 1'b0;
    bus.i_imem_we    = 1'b1;
    bus.i_imem_waddr = addr;
    bus.i_imem_wdata = data;
    tick();
    bus.i_imem_we    = 1'b0;
    m_mem[addr[9:2]] = data;
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    logic [96:0] e;
    clear_ctl();
    rst = 1'b1;
    #2;
    e = {32'h0, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", snap(), e);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) write_word(32'(i * 4), 32'h1000_0000 + 32'(i));
  endtask

  task automatic test_load_wrap();
    logic [96:0] e;
    write_word(32'h0000_0400, 32'h1234_5678);
    do_reset();
    bus.i_enable = 1'b1;
    tick();
    e = {32'h4, 32'h1234_5678, 32'h4, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL load_wrap: got %h expected %h", snap(), e);
    end
    // Write attempted while running must be dropped.
    do_reset();
    bus.i_imem_we    = 1'b1;
    bus.i_imem_waddr = 32'h0000_0400;
    bus.i_imem_wdata = 32'hDEAD_BEEF;
    tick();
    bus.i_imem_we = 1'b0;
    bus.i_enable  = 1'b0;
    do_reset();
    bus.i_enable = 1'b1;
    tick();
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL write_while_enabled: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] seq [3];
    logic [96:0] e;
    seq = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    for (int i = 0; i < 3; i++) write_word(32'(i * 4), seq[i]);
    do_reset();
    bus.i_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = {32'(4 * (i + 1)), seq[i], 32'(4 * (i + 1)), 1'b0};
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL seq_fetch[%0d]: got %h expected %h", i, snap(), e);
      end
    end
  endtask

  task automatic test_stall();
    logic [96:0] e;
    clear_ctl();
    do_reset();
    bus.i_enable = 1'b1;
    run_ticks(2);
    bus.i_stall = 1'b1;
    e = {32'h8, 32'h2002_0007, 32'h8, 1'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, snap(), e);
      end
    end
    bus.i_stall = 1'b0;
    tick();
    e = {32'hC, 32'h0022_1820, 32'hC, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL stall_resume: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_branch();
    logic [96:0] e;
    clear_ctl();
    write_word(32'h40, 32'h8C01_0040);
    do_reset();
    bus.i_enable = 1'b1;
    run_ticks(4);
    bus.i_pc_src       = 1'b1;
    bus.i_beq_jump_dir = 32'h40;
    tick();
    e = {32'h40, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL branch_bubble: got %h expected %h", snap(), e);
    end
    bus.i_pc_src = 1'b0;
    tick();
    e = {32'h44, 32'h8C01_0040, 32'h44, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL branch_target: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_priority();
    logic [96:0] e;
    clear_ctl();
    do_reset();
    bus.i_enable = 1'b1;
    tick();
    bus.i_pc_src = 1'b1; bus.i_beq_jump_dir = 32'h40;
    bus.i_jump   = 1'b1; bus.i_jump_addr    = 32'h80;
    tick();
    e = {32'h40, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL branch_over_jump: got %h expected %h", snap(), e);
    end
    bus.i_pc_src = 1'b0; bus.i_jump = 1'b0;
    tick();
    bus.i_stall = 1'b1; bus.i_pc_src = 1'b1; bus.i_jump = 1'b1;
    tick();
    e = {32'h44, 32'h8C01_0040, 32'h44, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL stall_over_redirect: got %h expected %h", snap(), e);
    end
    bus.i_stall = 1'b0; bus.i_pc_src = 1'b0; bus.i_jump_addr = 32'hFFFF_FFFC;
    tick();
    e = {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL jump_only: got %h expected %h", snap(), e);
    end
    bus.i_jump = 1'b0;
    tick();
    e = {32'h0, 32'h1000_00FF, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL pc_wrap: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_halt();
    logic [96:0] e;
    clear_ctl();
    write_word(32'hC, HALT);
    do_reset();
    bus.i_enable = 1'b1;
    run_ticks(3);
    tick();
    e = {32'hC, HALT, 32'h10, 1'b1};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL halt_commit: got %h expected %h", snap(), e);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL halt_frozen[%0d]: got %h expected %h", i, snap(), e);
      end
    end
    // HALT in a flushed slot is squashed.
    do_reset();
    run_ticks(3);
    bus.i_pc_src = 1'b1; bus.i_beq_jump_dir = 32'h40;
    tick();
    bus.i_pc_src = 1'b0;
    e = {32'h40, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL halt_squashed: got %h expected %h", snap(), e);
    end
    // HALT under stall waits for the stall to clear.
    do_reset();
    run_ticks(3);
    bus.i_stall = 1'b1;
    run_ticks(2);
    e = {32'hC, 32'h0022_1820, 32'hC, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL halt_stalled: got %h expected %h", snap(), e);
    end
    bus.i_stall = 1'b0;
    tick();
    e = {32'hC, HALT, 32'h10, 1'b1};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL halt_after_stall: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_reset_midrun();
    logic [96:0] e;
    clear_ctl();
    write_word(32'hC, 32'h1000_000C);
    do_reset();
    bus.i_enable = 1'b1;
    run_ticks(5);
    e = {32'h14, 32'h1000_0004, 32'h14, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL pre_reset_pc: got %h expected %h", snap(), e);
    end
    #2;
    rst = 1'b1;
    #1;
    e = {32'h0, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", snap(), e);
    end
    rst = 1'b0;
    model_reset();
    tick();
    e = {32'h4, 32'h2001_0005, 32'h4, 1'b0};
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL refetch_after_reset: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_random();
    logic [96:0] e;
    clear_ctl();
    for (int i = 0; i < 40; i++) begin
      write_word($urandom_range(0, 255) * 4,
                 ($urandom_range(0, 7) == 0) ? HALT : $urandom);
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.i_enable       = ($urandom_range(0, 9) != 0);
      bus.i_stall        = ($urandom_range(0, 3) == 0);
      bus.i_pc_src       = ($urandom_range(0, 9) == 0);
      bus.i_jump         = ($urandom_range(0, 9) == 0);
      bus.i_beq_jump_dir = $urandom & 32'hFFFF_FFFC;
      bus.i_jump_addr    = 32'($urandom_range(0, 255) * 4);
      bus.i_imem_we      = ($urandom_range(0, 5) == 0);
      bus.i_imem_waddr   = $urandom;
      bus.i_imem_wdata   = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      model_step();
      tick();
      e = model_snap();
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", c, snap(), e);
      end
      if ((m_halt && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
        e = model_snap();
        n_checks++;
        if (snap() !== e) begin
          n_fail++; $display("FAIL random_reset[%0d]: got %h expected %h", c, snap(), e);
        end
      end
    end
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_load_wrap();
    test_sequential();
    test_stall();
    test_branch();
    test_priority();
    test_halt();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the decode stage.
- Holds the PC and an internal loadable instruction memory.
- Picks the next PC from the branch/jump redirects that decode produces.
- Latches {instruction, PC+4} into IF/ID, honouring decode's stall and flushing on a taken redirect.
- Detects HALT and freezes fetch.

Parameters:
IMEM_DEPTH, 256, instruction memory size in 32-bit words; power of 2.
PC_RESET, 32'h0000_0000, PC value after reset.
HALT_WORD, 32'hFFFF_FFFF, encoding of the HALT instruction.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  run enable; 0 freezes PC and IF/ID and allows loading
i_stall  in  1  hold PC and IF/ID (load-use hazard from decode)
i_pc_src  in  1  taken conditional branch resolved in decode
i_beq_jump_dir  in  32  branch target from decode
i_jump  in  1  unconditional jump decoded in decode
i_jump_addr  in  32  jump target from decode
i_imem_we  in  1  instruction memory write strobe
i_imem_waddr  in  32  byte address of word to write; bits [1:0] ignored
i_imem_wdata  in  32  instruction word to write
o_pc  out  32  current PC
o_instruction  out  32  IF/ID instruction
o_pc_plus_4  out  32  IF/ID PC+4
o_halt  out  1  sticky: HALT fetched and committed to IF/ID

Behaviour:
- Reset (async, immediate) values: PC=PC_RESET, o_instruction=0 (NOP), o_pc_plus_4=0, o_halt=0. Memory contents are not reset.
- Memory read: combinational at index PC[log2(IMEM_DEPTH)+1:2]. Upper PC bits are ignored, so the address wraps modulo IMEM_DEPTH words.
- Memory write: synchronous, only when i_imem_we=1 and i_enable=0; ignored while i_enable=1.
- PC+4: unsigned 32-bit add, wraps 32'hFFFF_FFFC -> 0.
- Next-PC priority, evaluated each edge:
  1. i_enable=0 or o_halt=1: hold.
  2. i_stall=1: hold. A redirect is ignored while stalled; decode re-asserts it after the stall.
  3. i_pc_src=1: i_beq_jump_dir.
  4. i_jump=1: i_jump_addr. If both redirects are high, branch wins.
  5. Otherwise PC+4.
- IF/ID update, same priority:
  - Hold when disabled, halted or stalled.
  - Taken redirect (i_pc_src or i_jump, not stalled): flush. o_instruction=0, o_pc_plus_4=0.
  - Otherwise load {mem[PC], PC+4}.
- Latency: the instruction at PC appears on o_instruction 1 cycle after PC presents it. A taken redirect costs exactly 1 bubble.
- HALT:
  - When mem[PC]==HALT_WORD and it is normally loaded into IF/ID (no flush, no stall, enabled), it is loaded like any instruction.
  - On that same edge o_halt<=1 and PC holds.
  - While halted, IF/ID holds its current contents with no further loads.
  - Exit is by reset only.
- HALT in the slot being flushed by a taken redirect is squashed: o_halt stays 0 and the PC redirects.
- HALT fetched while i_stall=1: nothing happens until the stall clears.
- Reset asserted mid-run clears state immediately, independent of the clock. The first fetch after release is from PC_RESET.

Test Plan:
- Sequential fetch: load words 0x20010005, 0x20020007, 0x00221820 at 0/4/8, enable -> o_instruction follows those words on successive cycles; o_pc_plus_4 = 4, 8, 12.
- Stall: assert i_stall for 2 cycles at PC=8 -> PC stays 8, IF/ID holds 0x20020007/8 for 2 cycles, then resumes with 0x00221820/12.
- Taken branch: i_pc_src=1, i_beq_jump_dir=0x40 at PC=0x10 -> next PC=0x40; IF/ID=0/0 for one cycle; then mem[0x40]/0x44.
- Priority: i_pc_src=1 and i_jump=1 (targets 0x40, 0x80) -> PC=0x40. Same with i_stall=1 -> PC unchanged, no flush.
- HALT: HALT at 0x0C -> o_halt=1 on the edge it loads, PC frozen at 0x0C for 10 cycles. HALT at 0x0C with a taken branch that cycle -> o_halt=0, PC=target.
- Reset/load: reset mid-run at PC=0x14 -> PC=0 and o_instruction=0 immediately. Write 0x12345678 at waddr 0x400 with IMEM_DEPTH=256 -> lands at word 0 (wrap). The same write with i_enable=1 -> memory unchanged.
